// File: rtl/ap_hs_txn_recorder_if.sv
// ap_hs_txn_recorder_if
//   Bundles the observed ap_ctrl_hs handshake of one block with the
//   record stream that drains the recorder's FIFO.
//   Handshake (master -> slave): ap_start, ap_ready, ap_done, ap_continue
//   Record stream (slave -> master): rec_valid, rec_id, rec_latency, rec_interval
//   Record stream (master -> slave): rec_ready
//   master: the side that drives the block handshake and consumes records
//   slave : the recorder
interface ap_hs_txn_recorder_if #(
  parameter int CNT_W = 32,
  parameter int ID_W  = 16
);
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             rec_valid;
  logic             rec_ready;
  logic [ID_W-1:0]  rec_id;
  logic [CNT_W-1:0] rec_latency;
  logic [CNT_W-1:0] rec_interval;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    input  rec_valid, rec_id, rec_latency, rec_interval
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, rec_ready,
    output rec_valid, rec_id, rec_latency, rec_interval
  );
endinterface

// File: rtl/ap_hs_txn_recorder.sv
// ap_hs_txn_recorder
//   Watches one ap_ctrl_hs block and produces one record per transaction:
//   {id, start->done latency, start->start interval}. Records go into a
//   first-word-fall-through FIFO drained over a valid/ready stream.
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears all state
//   hs           handshake observation + record stream (slave modport)
//   finish_i     end-of-run indication, latched sticky
//   txn_count_o  push attempts so far (wraps)
//   drop_count_o records lost to a full FIFO (saturates at 0xFFFF)
//   proto_err_o  sticky: ap_done or ap_ready seen in IDLE without ap_start
//   all_done_o   sticky: finish latched while IDLE with the FIFO empty
module ap_hs_txn_recorder #(
  parameter int CNT_W      = 32,
  parameter int ID_W       = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ap_hs_txn_recorder_if.slave  hs,
  input  logic                 finish_i,
  output logic [ID_W-1:0]      txn_count_o,
  output logic [15:0]          drop_count_o,
  output logic                 proto_err_o,
  output logic                 all_done_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_CONT} state_e;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] interval;
  } rec_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0] int_cnt_q, int_cnt_d;
  logic [CNT_W-1:0] int_cap_q, int_cap_d;   // interval of the transaction in flight
  logic             int_run_q, int_run_d;   // int_cnt only runs after the first start
  logic [ID_W-1:0]  id_q, id_d;
  logic [15:0]      drop_q, drop_d;
  logic             perr_q, perr_d;
  logic             fin_q, fin_d;
  logic             all_done_q, all_done_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  rec_t             mem [FIFO_DEPTH];

  logic [CNT_W-1:0] lat_inc, int_inc;
  logic             push_req, push_ok, pop, drop, empty, full;
  rec_t             push_rec, head;

  // Saturating increments shared by the counters and the pushed record.
  assign lat_inc = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + 1'b1;
  assign int_inc = (&int_cnt_q) ? int_cnt_q : int_cnt_q + 1'b1;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    int_cnt_d = int_run_q ? int_inc : int_cnt_q;
    int_cap_d = int_cap_q;
    int_run_d = int_run_q;
    perr_d    = perr_q;
    push_req  = 1'b0;
    push_rec  = '0;
    case (state_q)
      S_IDLE: begin
        if (hs.ap_start) begin
          // int_cnt holds (cycles since last start - 1), hence int_inc.
          int_cap_d = int_run_q ? int_inc : '0;
          int_cnt_d = '0;
          int_run_d = 1'b1;
          lat_cnt_d = '0;
          if (hs.ap_done) begin
            push_req          = 1'b1;
            push_rec.id       = id_q;
            push_rec.latency  = '0;
            push_rec.interval = int_cap_d;
            state_d           = hs.ap_continue ? S_IDLE : S_WAIT_CONT;
          end else begin
            state_d = S_RUN;
          end
        end else if (hs.ap_done || hs.ap_ready) begin
          perr_d = 1'b1;
        end
      end
      S_RUN: begin
        lat_cnt_d = lat_inc;
        if (hs.ap_done) begin
          push_req          = 1'b1;
          push_rec.id       = id_q;
          push_rec.latency  = lat_inc;
          push_rec.interval = int_cap_q;
          state_d           = hs.ap_continue ? S_IDLE : S_WAIT_CONT;
        end
      end
      S_WAIT_CONT: begin
        // ap_done may still be high here; the record was already pushed.
        if (hs.ap_continue) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: an extra pointer bit separates full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop     = !empty && hs.rec_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  always_comb begin
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    id_d       = push_req ? id_q + 1'b1 : id_q;
    drop_d     = (drop && !(&drop_q)) ? drop_q + 16'd1 : drop_q;
    fin_d      = fin_q | finish_i;
    all_done_d = all_done_q | (fin_q && (state_q == S_IDLE) && empty);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      int_cnt_q  <= '0;
      int_cap_q  <= '0;
      int_run_q  <= 1'b0;
      id_q       <= '0;
      drop_q     <= '0;
      perr_q     <= 1'b0;
      fin_q      <= 1'b0;
      all_done_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      int_cnt_q  <= int_cnt_d;
      int_cap_q  <= int_cap_d;
      int_run_q  <= int_run_d;
      id_q       <= id_d;
      drop_q     <= drop_d;
      perr_q     <= perr_d;
      fin_q      <= fin_d;
      all_done_q <= all_done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: the record storage has no reset; entries are only read between a
  // push and its pop, and the head fields below are forced to 0 when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[PTR_W-1:0]] <= push_rec;
  end

  assign head            = mem[rd_ptr_q[PTR_W-1:0]];
  assign hs.rec_valid    = !empty;
  assign hs.rec_id       = empty ? '0 : head.id;
  assign hs.rec_latency  = empty ? '0 : head.latency;
  assign hs.rec_interval = empty ? '0 : head.interval;

  assign txn_count_o  = id_q;
  assign drop_count_o = drop_q;
  assign proto_err_o  = perr_q;
  assign all_done_o   = all_done_q;
endmodule

// File: tb/tb_ap_hs_txn_recorder.sv
// tb_ap_hs_txn_recorder
//   Drives well-formed ap_ctrl_hs transactions (plus a few protocol errors),
//   predicts the records from the start/done cycle numbers and a queue model
//   of the FIFO, and compares what the consumer side pops.
module tb_ap_hs_txn_recorder;
  localparam int CNT_W = 32;
  localparam int ID_W  = 16;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             finish;
  logic [ID_W-1:0]  txn_count;
  logic [15:0]      drop_count;
  logic             proto_err;
  logic             all_done;

  ap_hs_txn_recorder_if #(.CNT_W(CNT_W), .ID_W(ID_W)) hs ();

  ap_hs_txn_recorder #(.CNT_W(CNT_W), .ID_W(ID_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .hs           (hs),
    .finish_i     (finish),
    .txn_count_o  (txn_count),
    .drop_count_o (drop_count),
    .proto_err_o  (proto_err),
    .all_done_o   (all_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned id;
    int unsigned lat;
    int unsigned ivl;
  } rec_s;

  rec_s        exp_q[$];    // model of FIFO contents
  rec_s        exp_pop[$];  // records the model says the consumer receives
  rec_s        obs_pop[$];  // records the consumer actually received
  rec_s        nil = '{0, 0, 0};
  int unsigned m_txn, m_drop;
  int          cyc, prev_start, vmis;
  bit          have_prev, rand_ready;
  int          checks, failures;

  function automatic bit rec_eq(input rec_s a, input rec_s b);
    return a.id == b.id && a.lat == b.lat && a.ivl == b.ivl;
  endfunction

  // -1 when the popped lists agree, -2 on a length difference, else index.
  function automatic int first_diff();
    if (obs_pop.size() != exp_pop.size()) return -2;
    foreach (obs_pop[i]) if (!rec_eq(obs_pop[i], exp_pop[i])) return i;
    return -1;
  endfunction

  function automatic void clear_model();
    exp_q.delete(); exp_pop.delete(); obs_pop.delete();
    m_txn = 0; m_drop = 0; have_prev = 0; vmis = 0;
  endfunction

  // One clock cycle: sample DUT mid-cycle, advance the model with the inputs
  // that the coming edge will see, then step past the edge.
  task automatic tick(input bit push, input rec_s r);
    rec_s o;
    bit   pop;
    @(negedge clk);
    if (hs.rec_valid !== (exp_q.size() != 0)) vmis++;
    if (hs.rec_valid === 1'b1 && hs.rec_ready === 1'b1) begin
      o.id = hs.rec_id; o.lat = hs.rec_latency; o.ivl = hs.rec_interval;
      obs_pop.push_back(o);
    end
    pop = (exp_q.size() != 0) && hs.rec_ready;
    if (pop) exp_pop.push_back(exp_q.pop_front());
    if (push) begin
      m_txn++;
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else if (m_drop < 65535) m_drop++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_ready) hs.rec_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    hs.ap_start = 0; hs.ap_ready = 0; hs.ap_done = 0; hs.ap_continue = 1;
    hs.rec_ready = 0; finish = 0; rand_ready = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // gap idle cycles, start, done lat cycles later, continue held low for w
  // cycles after done. Optionally pulses ap_start during the wait and/or
  // raises rec_ready only for the push cycle.
  task automatic run_txn(input int gap, input int lat, input int w,
                         input bit start_in_wait, input bit ready_at_push);
    rec_s r;
    bit   saved_ready;
    repeat (gap) tick(0, nil);
    r.id  = m_txn;
    r.lat = lat;
    r.ivl = have_prev ? cyc - prev_start : 0;
    have_prev  = 1;
    prev_start = cyc;
    saved_ready = hs.rec_ready;
    hs.ap_start = 1; hs.ap_ready = 1;
    if (lat == 0) begin
      hs.ap_done = 1; hs.ap_continue = (w == 0);
      if (ready_at_push) hs.rec_ready = 1;
      tick(1, r);
    end else begin
      hs.ap_done = 0;
      tick(0, nil);
      hs.ap_start = 0; hs.ap_ready = 0;
      repeat (lat - 1) tick(0, nil);
      hs.ap_done = 1; hs.ap_continue = (w == 0);
      if (ready_at_push) hs.rec_ready = 1;
      tick(1, r);
    end
    if (ready_at_push) hs.rec_ready = saved_ready;
    hs.ap_start = 0; hs.ap_ready = 0;
    for (int j = 1; j <= w; j++) begin
      hs.ap_continue = (j == w);
      hs.ap_start    = start_in_wait && (j == 1);
      tick(0, nil);
    end
    hs.ap_start = 0; hs.ap_done = 0; hs.ap_continue = 1;
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    hs.rec_ready = 1;
    while ((exp_q.size() != 0 || hs.rec_valid !== 1'b0) && n < 60) begin
      tick(0, nil);
      n++;
    end
    tick(0, nil);
    timed_out = (n >= 60);
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (hs.rec_valid !== 1'b0) begin failures++; $display("FAIL reset_rec_valid got=%b want=0", hs.rec_valid); end
    checks++; if (hs.rec_id !== '0) begin failures++; $display("FAIL reset_rec_id got=%0d want=0", hs.rec_id); end
    checks++; if (hs.rec_latency !== '0 || hs.rec_interval !== '0) begin failures++; $display("FAIL reset_rec_fields got=%0d/%0d want=0/0", hs.rec_latency, hs.rec_interval); end
    checks++; if (txn_count !== '0) begin failures++; $display("FAIL reset_txn_count got=%0d want=0", txn_count); end
    checks++; if (drop_count !== '0) begin failures++; $display("FAIL reset_drop_count got=%0d want=0", drop_count); end
    checks++; if (proto_err !== 1'b0 || all_done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", proto_err, all_done); end
  endtask

  task automatic test_single();
    reset_dut();
    hs.rec_ready = 1;
    run_txn(3, 3, 0, 0, 0);
    repeat (3) tick(0, nil);
    checks++; if (obs_pop.size() != 1) begin failures++; $display("FAIL single_count got=%0d want=1", obs_pop.size()); end
    else begin
      checks++; if (obs_pop[0].id != 0 || obs_pop[0].lat != 3 || obs_pop[0].ivl != 0) begin failures++; $display("FAIL single_rec got=%0d/%0d/%0d want=0/3/0", obs_pop[0].id, obs_pop[0].lat, obs_pop[0].ivl); end
    end
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL single_txn_count got=%0d want=1", txn_count); end
  endtask

  task automatic test_two_starts();
    reset_dut();
    hs.rec_ready = 1;
    run_txn(0, 2, 0, 0, 0);
    run_txn(2, 2, 0, 0, 0);
    repeat (3) tick(0, nil);
    checks++; if (obs_pop.size() != 2) begin failures++; $display("FAIL two_starts_count got=%0d want=2", obs_pop.size()); end
    else begin
      checks++; if (obs_pop[1].id != 1 || obs_pop[1].lat != 2 || obs_pop[1].ivl != 5) begin failures++; $display("FAIL two_starts_rec got=%0d/%0d/%0d want=1/2/5", obs_pop[1].id, obs_pop[1].lat, obs_pop[1].ivl); end
    end
  endtask

  task automatic test_wait_cont();
    bit to;
    reset_dut();
    run_txn(2, 1, 4, 1, 0);
    checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL wait_txn_count got=%0d want=1", txn_count); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL wait_proto_err got=%b want=0", proto_err); end
    run_txn(0, 2, 0, 0, 0);
    drain(to);
    checks++; if (to) begin failures++; $display("FAIL wait_drain_timeout got=timeout want=empty"); end
    checks++; if (first_diff() != -1) begin failures++; $display("FAIL wait_records got=%0d recs want=%0d (diff %0d)", obs_pop.size(), exp_pop.size(), first_diff()); end
  endtask

  task automatic test_fifo_full();
    bit to;
    int want;
    reset_dut();
    for (int t = 0; t < 10; t++)
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 1), 0, 0);
    checks++; if (drop_count !== 16'd2) begin failures++; $display("FAIL full_drop_count got=%0d want=2", drop_count); end
    checks++; if (txn_count !== 16'd10) begin failures++; $display("FAIL full_txn_count got=%0d want=10", txn_count); end
    run_txn(1, 0, 0, 0, 1);
    checks++; if (drop_count !== 16'd2 || exp_q.size() != DEPTH) begin failures++; $display("FAIL full_push_pop got=drop %0d want=drop 2 occ %0d", drop_count, exp_q.size()); end
    drain(to);
    checks++; if (to || first_diff() != -1) begin failures++; $display("FAIL full_records got=%0d recs want=%0d", obs_pop.size(), exp_pop.size()); end
    for (int i = 0; i < obs_pop.size(); i++) begin
      want = (i < 8) ? i : 10;
      checks++; if (obs_pop[i].id != want) begin failures++; $display("FAIL full_id[%0d] got=%0d want=%0d", i, obs_pop[i].id, want); end
    end
  endtask

  task automatic test_proto_err();
    reset_dut();
    hs.ap_done = 1;
    tick(0, nil);
    hs.ap_done = 0;
    repeat (2) tick(0, nil);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_done got=%b want=1", proto_err); end
    checks++; if (txn_count !== '0 || hs.rec_valid !== 1'b0) begin failures++; $display("FAIL proto_no_record got=txn %0d valid %b want=0 0", txn_count, hs.rec_valid); end
    reset_dut();
    hs.ap_ready = 1;
    tick(0, nil);
    hs.ap_ready = 0;
    repeat (2) tick(0, nil);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_ready got=%b want=1", proto_err); end
  endtask

  task automatic test_random();
    bit to;
    reset_dut();
    rand_ready = 1;
    for (int t = 0; t < 40; t++)
      run_txn($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 0);
    rand_ready = 0;
    checks++; if (drop_count !== 16'(m_drop)) begin failures++; $display("FAIL rand_drop got=%0d want=%0d", drop_count, m_drop); end
    checks++; if (txn_count !== ID_W'(m_txn)) begin failures++; $display("FAIL rand_txn got=%0d want=%0d", txn_count, m_txn); end
    drain(to);
    checks++; if (to || first_diff() != -1) begin failures++; $display("FAIL rand_records got=%0d recs want=%0d (diff %0d)", obs_pop.size(), exp_pop.size(), first_diff()); end
    checks++; if (vmis != 0) begin failures++; $display("FAIL rand_valid got=%0d mismatching cycles want=0", vmis); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rand_proto_err got=%b want=0", proto_err); end
  endtask

  task automatic test_reset_and_finish();
    bit to;
    int n;
    reset_dut();
    hs.rec_ready = 0;
    run_txn(1, 1, 0, 0, 0);
    hs.ap_start = 1; hs.ap_ready = 1;
    tick(0, nil);
    hs.ap_start = 0; hs.ap_ready = 0;
    tick(0, nil);
    #2 rst = 1'b1;
    #1;
    checks++; if (txn_count !== '0 || hs.rec_valid !== 1'b0) begin failures++; $display("FAIL async_reset got=txn %0d valid %b want=0 0", txn_count, hs.rec_valid); end
    @(posedge clk);
    #1;
    reset_dut();
    hs.rec_ready = 1;
    run_txn(2, 2, 0, 0, 0);
    drain(to);
    checks++; if (to || obs_pop.size() != 1 || obs_pop[0].id != 0 || obs_pop[0].ivl != 0) begin failures++; $display("FAIL post_reset_rec got=%0d recs want=1 rec id0 int0", obs_pop.size()); end
    checks++; if (all_done !== 1'b0) begin failures++; $display("FAIL all_done_early got=%b want=0", all_done); end
    finish = 1;
    tick(0, nil);
    finish = 0;
    n = 0;
    while (all_done !== 1'b1 && n < 20) begin tick(0, nil); n++; end
    checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL all_done got=%b want=1", all_done); end
    run_txn(1, 1, 0, 0, 0);
    drain(to);
    checks++; if (to || first_diff() != -1 || obs_pop.size() != 2) begin failures++; $display("FAIL after_all_done got=%0d recs want=2", obs_pop.size()); end
    checks++; if (all_done !== 1'b1) begin failures++; $display("FAIL all_done_sticky got=%b want=1", all_done); end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; prev_start = 0;
    rst = 1'b1;
    test_reset();
    test_single();
    test_two_starts();
    test_wait_cont();
    test_fifo_full();
    test_proto_err();
    test_random();
    test_reset_and_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
